mdu_ctrl: RTL and testbench

- Multiply/divide controller owned by the EX stage.
- Accepts one mult/multu/div/divu/mthi/mtlo per handshake and sequences a single-cycle multiplier and an iterative 32-step restoring divider.
- Owns the architectural HI/LO registers and reports busy so ID can block mfhi/mflo and any further MDU op until results land.

---
 rtl/mdu_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mdu_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide controller: single-cycle multiplier, 32-step
// restoring divider, and the architectural HI/LO registers.
module mdu_ctrl #(
   parameter int DIV_STEPS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [5:0]  op_code,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   input  logic        flush,
   output logic        busy,
   output logic [31:0] hi_rdata,
   output logic [31:0] lo_rdata
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   localparam logic [4:0] LAST = 5'(DIV_STEPS - 1);

   state_t      state_q, state_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] opa_q, opa_d, opb_q, opb_d;
   logic [31:0] rem_q, rem_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        msgn_q, msgn_d;
   logic        qsgn_q, qsgn_d;
   logic        rsgn_q, rsgn_d;

   logic        accept;
   logic [31:0] a_abs, b_abs;
   logic [63:0] a_ext, b_ext, prod;
   logic [32:0] shifted, trial;

   assign accept = op_valid && op_ready && !flush;
   assign a_abs  = src1[31] ? -src1 : src1;
   assign b_abs  = src2[31] ? -src2 : src2;

   // Low 64 bits of the extended product are exact for both signednesses
   assign a_ext = msgn_q ? {{32{opa_q[31]}}, opa_q} : {32'b0, opa_q};
   assign b_ext = msgn_q ? {{32{opb_q[31]}}, opb_q} : {32'b0, opb_q};
   assign prod  = a_ext * b_ext;

   // opa doubles as the dividend shifter and the quotient accumulator
   assign shifted = {rem_q, opa_q[31]};
   assign trial   = shifted - {1'b0, opb_q};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept && (op_code[5] || op_code[4])) begin
               state_d = DIV;
            end else if (accept && (op_code[3] || op_code[2])) begin
               state_d = MUL;
            end
         end
         MUL: state_d = IDLE;
         DIV: begin
            if (flush) begin
               state_d = IDLE;
            end else if (cnt_q == LAST) begin
               state_d = FIX;
            end
         end
         FIX: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      op_ready = (state_q == IDLE);
      busy     = (state_q != IDLE);
   end

   always_comb begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      opa_d  = opa_q;
      opb_d  = opb_q;
      rem_d  = rem_q;
      cnt_d  = cnt_q;
      msgn_d = msgn_q;
      qsgn_d = qsgn_q;
      rsgn_d = rsgn_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               unique case (1'b1)
                  op_code[5]: begin
                     opa_d  = a_abs;
                     opb_d  = b_abs;
                     qsgn_d = src1[31] ^ src2[31];
                     rsgn_d = src1[31];
                     rem_d  = '0;
                     cnt_d  = '0;
                  end
                  op_code[4]: begin
                     opa_d  = src1;
                     opb_d  = src2;
                     qsgn_d = 1'b0;
                     rsgn_d = 1'b0;
                     rem_d  = '0;
                     cnt_d  = '0;
                  end
                  op_code[3]: begin
                     opa_d  = src1;
                     opb_d  = src2;
                     msgn_d = 1'b1;
                  end
                  op_code[2]: begin
                     opa_d  = src1;
                     opb_d  = src2;
                     msgn_d = 1'b0;
                  end
                  op_code[1]: hi_d = src1;
                  op_code[0]: lo_d = src1;
                  default: ;
               endcase
            end
         end
         MUL: begin
            if (!flush) begin
               {hi_d, lo_d} = prod;
            end
         end
         DIV: begin
            rem_d = trial[32] ? shifted[31:0] : trial[31:0];
            opa_d = {opa_q[30:0], ~trial[32]};
            cnt_d = cnt_q + 5'd1;
         end
         FIX: begin
            if (!flush) begin
               lo_d = qsgn_q ? -opa_q : opa_q;
               hi_d = rsgn_q ? -rem_q : rem_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q   <= '0;
         lo_q   <= '0;
         opa_q  <= '0;
         opb_q  <= '0;
         rem_q  <= '0;
         cnt_q  <= '0;
         msgn_q <= 1'b0;
         qsgn_q <= 1'b0;
         rsgn_q <= 1'b0;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         opa_q  <= opa_d;
         opb_q  <= opb_d;
         rem_q  <= rem_d;
         cnt_q  <= cnt_d;
         msgn_q <= msgn_d;
         qsgn_q <= qsgn_d;
         rsgn_q <= rsgn_d;
      end
   end

   assign hi_rdata = hi_q;
   assign lo_rdata = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed cases with literal results, then random
// traffic compared every cycle against a cycles-remaining reference model.
module tb_mdu_ctrl;

   localparam logic [5:0] C_DIV   = 6'b100000;
   localparam logic [5:0] C_DIVU  = 6'b010000;
   localparam logic [5:0] C_MULT  = 6'b001000;
   localparam logic [5:0] C_MULTU = 6'b000100;
   localparam logic [5:0] C_MTHI  = 6'b000010;
   localparam logic [5:0] C_MTLO  = 6'b000001;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        op_valid = 1'b0;
   logic        flush = 1'b0;
   logic [5:0]  op_code = '0;
   logic [31:0] src1 = '0;
   logic [31:0] src2 = '0;
   logic        op_ready;
   logic        busy;
   logic [31:0] hi_rdata;
   logic [31:0] lo_rdata;

   always #5 clk = ~clk;

   mdu_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .op_valid (op_valid),
      .op_ready (op_ready),
      .op_code  (op_code),
      .src1     (src1),
      .src2     (src2),
      .flush    (flush),
      .busy     (busy),
      .hi_rdata (hi_rdata),
      .lo_rdata (lo_rdata)
   );

   int errs = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         if (errs <= 40)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] mul_ref(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic sg);
      longint p;
      longint unsigned u;
      if (sg) begin
         p = longint'($signed(a)) * longint'($signed(b));
         return p;
      end
      u = longint'(a) * longint'(b);
      return u;
   endfunction

   function automatic logic [63:0] div_ref(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic sg);
      logic [31:0] am, bm, q, r;
      am = (sg && a[31]) ? -a : a;
      bm = (sg && b[31]) ? -b : b;
      if (bm == 0) begin
         q = 32'hFFFF_FFFF;
         r = am;
      end else begin
         q = am / bm;
         r = am % bm;
      end
      if (sg && (a[31] ^ b[31])) q = -q;
      if (sg && a[31]) r = -r;
      return {r, q};
   endfunction

   // Reference: cycles left until the pending result lands
   int          left = 0;
   logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

   always @(posedge clk) begin
      if (reset) begin
         left = 0;
         m_hi = '0;
         m_lo = '0;
      end else if (left > 0) begin
         if (flush) begin
            left = 0;
         end else begin
            left--;
            if (left == 0) begin
               m_hi = p_hi;
               m_lo = p_lo;
            end
         end
      end else if (op_valid && !flush) begin
         case (op_code)
            C_DIV:   begin {p_hi, p_lo} = div_ref(src1, src2, 1'b1); left = 33; end
            C_DIVU:  begin {p_hi, p_lo} = div_ref(src1, src2, 1'b0); left = 33; end
            C_MULT:  begin {p_hi, p_lo} = mul_ref(src1, src2, 1'b1); left = 1; end
            C_MULTU: begin {p_hi, p_lo} = mul_ref(src1, src2, 1'b0); left = 1; end
            C_MTHI:  m_hi = src1;
            C_MTLO:  m_lo = src1;
            default: ;
         endcase
      end
   end

   logic chk_en = 1'b0;
   logic prev_busy = 1'b0;
   int   rises = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", busy, left > 0);
         chk("op_ready", op_ready, left == 0);
         chk("hi", hi_rdata, m_hi);
         chk("lo", lo_rdata, m_lo);
         if (busy && !prev_busy) rises++;
         prev_busy = busy;
      end
   end

   task automatic run_op(input logic [5:0] c, input logic [31:0] a,
                         input logic [31:0] b, output int nb);
      int k = 0;
      while (!op_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      op_valid = 1'b1;
      op_code  = c;
      src1     = a;
      src2     = b;
      @(negedge clk);
      op_valid = 1'b0;
      op_code  = '0;
      nb = 0;
      while (busy && nb < 100) begin
         @(negedge clk);
         nb++;
      end
   endtask

   function automatic logic [31:0] rval();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [5:0] rop();
      case ($urandom_range(0, 7))
         0: return C_DIV;
         1: return C_DIVU;
         2: return C_MULT;
         3: return C_MULTU;
         4: return C_MTHI;
         5: return C_MTLO;
         6: return C_DIV;
         default: return 6'b000000;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int nb, k, r0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk_en = 1'b1;
      chk("rst_hi", hi_rdata, 32'h0);
      chk("rst_lo", lo_rdata, 32'h0);
      chk("rst_ready", op_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);

      run_op(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb);
      chk("multu_cycles", nb, 1);
      chk("multu_hi", hi_rdata, 32'hFFFF_FFFE);
      chk("multu_lo", lo_rdata, 32'h0000_0001);

      run_op(C_MULT, 32'hFFFF_FFFE, 32'd3, nb);
      chk("mult_hi", hi_rdata, 32'hFFFF_FFFF);
      chk("mult_lo", lo_rdata, 32'hFFFF_FFFA);

      r0 = rises;
      run_op(C_MTHI, 32'h1234_5678, 32'h0, nb);
      chk("mthi_cycles", nb, 0);
      chk("mthi_no_busy", rises - r0, 0);
      chk("mthi_hi", hi_rdata, 32'h1234_5678);
      chk("mthi_lo", lo_rdata, 32'hFFFF_FFFA);

      run_op(C_DIV, 32'hFFFF_FFF9, 32'd2, nb);
      chk("div_cycles", nb, 33);
      chk("div_lo", lo_rdata, 32'hFFFF_FFFD);
      chk("div_hi", hi_rdata, 32'hFFFF_FFFF);

      run_op(C_DIVU, 32'd100, 32'd7, nb);
      chk("divu_lo", lo_rdata, 32'h0000_000E);
      chk("divu_hi", hi_rdata, 32'h0000_0002);

      run_op(C_DIVU, 32'd5, 32'd0, nb);
      chk("divu0_lo", lo_rdata, 32'hFFFF_FFFF);
      chk("divu0_hi", hi_rdata, 32'h0000_0005);

      run_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb);
      chk("divmin_lo", lo_rdata, 32'h8000_0000);
      chk("divmin_hi", hi_rdata, 32'h0);

      run_op(C_MTHI, 32'hAAAA_0000, 32'h0, nb);
      run_op(C_MTLO, 32'h0000_BBBB, 32'h0, nb);
      op_valid = 1'b1;
      op_code  = C_DIVU;
      src1     = 32'd100;
      src2     = 32'd7;
      @(negedge clk);
      op_valid = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_ready", op_ready, 1'b1);
      chk("flush_busy", busy, 1'b0);
      chk("flush_hi", hi_rdata, 32'hAAAA_0000);
      chk("flush_lo", lo_rdata, 32'h0000_BBBB);

      r0 = rises;
      op_valid = 1'b1;
      op_code  = C_DIVU;
      @(negedge clk);
      op_code = C_MULT;
      src1    = 32'd6;
      src2    = 32'd7;
      k = 0;
      while (!op_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("held_wait", k < 100, 1'b1);
      @(negedge clk);
      op_valid = 1'b0;
      k = 0;
      while (busy && k < 100) begin
         @(negedge clk);
         k++;
      end
      repeat (3) @(negedge clk);
      chk("held_accepts", rises - r0, 2);
      chk("held_lo", lo_rdata, 32'd42);
      chk("held_hi", hi_rdata, 32'd0);

      run_op(C_MTHI, 32'h5555_5555, 32'h0, nb);
      op_valid = 1'b1;
      op_code  = C_DIV;
      src1     = 32'd1000;
      src2     = 32'd3;
      @(negedge clk);
      op_valid = 1'b0;
      repeat (19) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rstmid_hi", hi_rdata, 32'h0);
      chk("rstmid_lo", lo_rdata, 32'h0);
      chk("rstmid_busy", busy, 1'b0);
      chk("rstmid_ready", op_ready, 1'b1);
      run_op(C_MULT, 32'd6, 32'd7, nb);
      chk("post_rst_lo", lo_rdata, 32'd42);
      chk("post_rst_hi", hi_rdata, 32'd0);

      for (int i = 0; i < 4000; i++) begin
         reset    = ($urandom_range(0, 999) < 3);
         flush    = ($urandom_range(0, 99) < 2);
         op_valid = ($urandom_range(0, 3) != 0);
         op_code  = rop();
         src1     = rval();
         src2     = rval();
         @(negedge clk);
      end
      reset    = 1'b0;
      flush    = 1'b0;
      op_valid = 1'b0;
      op_code  = '0;
      repeat (40) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
